// File: rtl/shamt_shift_sequencer_if.sv
// Start/busy/done handshake and data bus between the multicycle control unit
// and the shift sequencer.
interface shamt_shift_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   A;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   Y;
  logic               busy;
  logic               done;

  modport master (output start, output op, output A, output shamt,
                  input  Y, input busy, input done);
  modport slave  (input  start, input op, input A, input shamt,
                  output Y, output busy, output done);
endinterface

// File: rtl/shamt_shift_sequencer.sv
// One-bit-per-cycle shift sequencer (SLL/SRL/SRA) that replaces a barrel shifter.
// Optional macro SHSEQ_ROTATE_EN: op=11 rotates right; otherwise op=11 acts as SRL.
module shamt_shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  shamt_shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [WIDTH-1:0]   r_y;
  logic [SHAMT_W-1:0] r_count;
  logic [1:0]         r_op;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   w_shifted;

  function automatic logic [WIDTH-1:0] shift_by_one(input logic [WIDTH-1:0] y,
                                                     input logic [1:0]       op);
    logic [WIDTH-1:0] res;
    case (op)
      2'b00:   res = {y[WIDTH-2:0], 1'b0};
      2'b01:   res = {1'b0, y[WIDTH-1:1]};
      2'b10:   res = {y[WIDTH-1], y[WIDTH-1:1]};
`ifdef SHSEQ_ROTATE_EN
      2'b11:   res = {y[0], y[WIDTH-1:1]};
`else
      2'b11:   res = {1'b0, y[WIDTH-1:1]};
`endif
      default: res = {1'b0, y[WIDTH-1:1]};
    endcase
    return res;
  endfunction

  // Next value of the shifter register for the latched operation.
  always_comb begin
    w_shifted = {WIDTH{1'b0}};
    w_shifted = shift_by_one(r_y, r_op);
  end

  // Sequencer FSM; busy/done are registered alongside the state so they stay Moore.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_y     <= {WIDTH{1'b0}};
      r_count <= CNT_ZERO;
      r_op    <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_y     <= bus.A;
            r_count <= bus.shamt;
            r_op    <= bus.op;
            r_busy  <= 1'b1;
            if (bus.shamt == CNT_ZERO) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
              r_done  <= 1'b0;
            end
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_y     <= w_shifted;
          r_count <= r_count - CNT_ONE;
          r_busy  <= 1'b1;
          if (r_count == CNT_ONE) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_SHIFT;
            r_done  <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Y    = r_y;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_shamt_shift_sequencer.sv
// Directed-vector bench for shamt_shift_sequencer; expected values are hand-computed.
// Honours SHSEQ_ROTATE_EN for the op=11 vector.
module tb_shamt_shift_sequencer;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  shamt_shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) u_if ();

  shamt_shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Accepts one operation, optionally re-pulses start with A=0 at cycle restart_at,
  // and checks latency, busy occupancy, result and the one-cycle done pulse.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [4:0] sh, input logic [31:0] exp_y, input int restart_at);
    int k;
    int busy_c;
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.op    = op;
    u_if.A     = a;
    u_if.shamt = sh;
    @(posedge clk);
    @(negedge clk);
    u_if.start = 1'b0;
    k      = 1;
    busy_c = 0;
    while (!u_if.done && k < 100) begin
      if (u_if.busy) busy_c++;
      @(negedge clk);
      k++;
      if (k == restart_at) begin
        u_if.start = 1'b1;
        u_if.A     = 32'h0000_0000;
        u_if.shamt = 5'd3;
      end else begin
        u_if.start = 1'b0;
      end
    end
    u_if.start = 1'b0;
    if (u_if.busy) busy_c++;
    chk_vec({tag, "_latency"}, 32'(k), 32'(sh) + 32'd1);
    chk_vec({tag, "_busy_cycles"}, 32'(busy_c), 32'(sh) + 32'd1);
    chk_vec({tag, "_y"}, u_if.Y, exp_y);
    @(negedge clk);
    chk_vec({tag, "_done_pulse"}, {31'd0, u_if.done}, 32'd0);
    chk_vec({tag, "_busy_drop"}, {31'd0, u_if.busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_rot;
    int          saw_done;
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    u_if.start = 1'b0;
    u_if.op    = 2'b00;
    u_if.A     = 32'h0000_0000;
    u_if.shamt = 5'd0;
    #1;
    chk_vec("reset_y", u_if.Y, 32'h0000_0000);
    chk_vec("reset_busy", {31'd0, u_if.busy}, 32'd0);
    chk_vec("reset_done", {31'd0, u_if.done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("sll27", 2'b00, 32'h0000_0001, 5'd27, 32'h0800_0000, 0);
    repeat (5) @(negedge clk);
    chk_vec("sll27_hold_y", u_if.Y, 32'h0800_0000);
    chk_vec("sll27_hold_busy", {31'd0, u_if.busy}, 32'd0);

    do_op("sra4", 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, 0);
    do_op("srl4", 2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000, 0);

    for (int i = 0; i < 4; i++) begin
      do_op($sformatf("zero_op%0d", i), 2'(i), 32'h1234_5678, 5'd0, 32'h1234_5678, 0);
    end

    do_op("sll31_restart", 2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 5);
    repeat (3) @(negedge clk);
    chk_vec("sll31_no_requeue", {31'd0, u_if.busy}, 32'd0);

    // Reset mid-operation: SRL by 20, rst_n dropped at cycle 10 between edges.
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.op    = 2'b01;
    u_if.A     = 32'hFFFF_FFFF;
    u_if.shamt = 5'd20;
    @(posedge clk);
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (9) @(negedge clk);
    chk_vec("rst_mid_busy_before", {31'd0, u_if.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_vec("rst_mid_y", u_if.Y, 32'h0000_0000);
    chk_vec("rst_mid_busy", {31'd0, u_if.busy}, 32'd0);
    chk_vec("rst_mid_done", {31'd0, u_if.done}, 32'd0);
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (u_if.done) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (u_if.done) saw_done = 1;
    end
    chk_vec("rst_mid_no_done", 32'(saw_done), 32'd0);
    do_op("after_rst", 2'b01, 32'hFFFF_FFFF, 5'd20, 32'h0000_0FFF, 0);

`ifdef SHSEQ_ROTATE_EN
    exp_rot = 32'h8000_0001;
`else
    exp_rot = 32'h0000_0001;
`endif
    do_op("op11", 2'b11, 32'h0000_0003, 5'd1, exp_rot, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shamt_shift_sequencer.md
Name: shamt_shift_sequencer

Overview:
- Multicycle shift controller for the shift datapath.
- Takes a 5-bit shift amount (shamt field), zero-extended internally to the counter width. Sequences a 1-bit-per-cycle shifter register until the count is exhausted.
- Provides a start/busy/done handshake to the multicycle control unit.
- Replaces a combinational barrel shifter where area matters.

Parameters:
- WIDTH, 32, data path width in bits.
- SHAMT_W, 5, shift-amount field width; shamt is zero-extended, never sign-extended.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00=SLL, 01=SRL, 10=SRA, 11=see Optional Feature.
- A  input  WIDTH  operand; captured on the accepting edge.
- shamt  input  SHAMT_W  shift amount, unsigned 0..31; captured on the accepting edge.
- Y  output  WIDTH  result register.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; Y valid while high.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, Y=0, busy=0, done=0, count=0. Takes effect mid-operation with no completion pulse. The operation is lost.
- States: IDLE, SHIFT, DONE. Moore outputs: busy=(state!=IDLE), done=(state==DONE).
- IDLE with start=1 at edge E0:
  - Load Y←A, count←zero-extend(shamt), latch op.
  - Next state is DONE if shamt==0, else SHIFT.
- IDLE with start=0: hold. Y keeps the last result indefinitely.
- SHIFT, each edge: Y←shift-by-1(Y, op), count←count−1. If count==1 before the decrement, next state is DONE; otherwise stay in SHIFT.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: done is high in the cycle following edge E0+shamt.
  - shamt=0: done in the cycle right after E0, Y=A.
  - Total occupancy: shamt+1 cycles.
- Shift-by-1 rules:
  - SLL: {Y[WIDTH-2:0],0}.
  - SRL: {0,Y[WIDTH-1:1]}.
  - SRA: {Y[WIDTH-1],Y[WIDTH-1:1]}.
- start while busy (SHIFT or DONE) is ignored. No queuing, no restart. A, shamt and op changes while busy have no effect.
- Back-to-back: start asserted during the DONE cycle is ignored. It is accepted on the next edge if still high in IDLE.
- Count never wraps: it is loaded with at most 2^SHAMT_W−1 and stops at 1→DONE.
- Y is undefined-free: it is registered at all times and never X after reset.

Optional Feature:
- Macro: SHSEQ_ROTATE_EN.
- Defined: op=11 performs rotate right, {Y[0],Y[WIDTH-1:1]}, with identical timing.
- Not defined: op=11 behaves exactly as SRL (01). No illegal-op flag exists.

Test Plan:
- SLL, A=32'h0000_0001, shamt=27, start one cycle → busy high 28 cycles; done after edge E0+27; Y=32'h0800_0000; Y held afterwards with start low.
- SRA, A=32'h8000_0000, shamt=4 → Y=32'hF800_0000. SRL with the same inputs → Y=32'h0800_0000. done pulse exactly one cycle each.
- shamt=0, A=32'h1234_5678, any op → done in the cycle after E0; Y=32'h1234_5678; busy high exactly one cycle.
- SLL, A=32'hFFFF_FFFF, shamt=31 → Y=32'h8000_0000. start re-pulsed with A=0 at cycle 5 is ignored; the result is unchanged.
- Reset mid-operation: SRL, shamt=20, rst_n low at cycle 10 → Y=0, busy=0, done=0 immediately without waiting for an edge. No done pulse. A new start after release completes normally.
- op=11, A=32'h0000_0003, shamt=1 → with SHSEQ_ROTATE_EN: Y=32'h8000_0001; without: Y=32'h0000_0001.
